piso_serializer: RTL and testbench

Parallel-in/serial-out stage that sits directly downstream of the 4-bit shift/complement register. It captures that register's parallel word through a valid/ready handshake and emits it one bit per clock with frame markers. A hold input stalls the stream. WIDTH is parameterised so the same block serves wider datapaths.

---
 rtl/piso_serializer.sv | 126 ++++++++++++
 tb/tb_piso_serializer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: captures a WIDTH-bit word via valid/ready, emits one bit per clk with frame markers.
// Latency: first bit the cycle after capture; WIDTH bits (+1 parity with PISO_PARITY_EN) plus hold cycles per frame.
// Backpressure: load_ready only in IDLE; hold freezes the stream in SHIFT/PARITY. Optional parity: `define PISO_PARITY_EN.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             hold,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             out_bit;
  logic [WIDTH-1:0] sreg_shifted;

  // The output end depends on bit order; shifting always moves toward it with zero fill.
  assign out_bit      = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
  assign sreg_shifted = LSB_FIRST ? {1'b0, sreg_q[WIDTH-1:1]}
                                  : {sreg_q[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
`ifdef PISO_PARITY_EN
    par_d       = par_q;
`endif
    load_ready  = 1'b0;
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    busy        = 1'b0;

    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          sreg_d  = data_in;
          cnt_d   = '0;
`ifdef PISO_PARITY_EN
          par_d   = ^data_in;
`endif
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        busy        = 1'b1;
        ser_out     = out_bit;
        ser_valid   = !hold;
        frame_start = !hold && (cnt_q == '0);
        if (!hold) begin
          sreg_d = sreg_shifted;
          if (cnt_q == LAST_CNT) begin
            // Clear rather than increment so the counter never wraps inside a frame.
            cnt_d = '0;
`ifdef PISO_PARITY_EN
            state_d = PARITY;
`else
            frame_done = 1'b1;
            state_d    = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

`ifdef PISO_PARITY_EN
      PARITY: begin
        busy       = 1'b1;
        ser_out    = par_q;
        ser_valid  = !hold;
        frame_done = !hold;
        if (!hold) state_d = IDLE;
      end
`endif

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances against a per-frame bit-list reference model.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_valid = 1'b0;
  logic         hold = 1'b0;
  logic [W-1:0] data_in = '0;

  logic [1:0] lr, so, sv, fs, fd, bz;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(lr[0]), .hold(hold), .ser_out(so[0]), .ser_valid(sv[0]),
    .frame_start(fs[0]), .frame_done(fd[0]), .busy(bz[0])
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(lr[1]), .hold(hold), .ser_out(so[1]), .ser_valid(sv[1]),
    .frame_start(fs[1]), .frame_done(fd[1]), .busy(bz[1])
  );

  // Reference model: a frame is just the ordered list of bits to emit plus a position in it.
  bit           m_busy [2];
  logic [W:0]   m_bits [2];
  int           m_idx  [2];
  int           tests = 0;
  int           fails = 0;

  function automatic logic [W:0] frame_bits(input logic [W-1:0] w, input bit lsb);
    logic [W:0] b;
    for (int i = 0; i < W; i++) b[i] = lsb ? w[i] : w[W-1-i];
    b[W] = ^w;
    return b;
  endfunction

  task automatic chk(input string tag, input int d, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: observed %b expected %b", tag, d, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic lv, input logic [W-1:0] din,
                      input logic hd, input bit do_chk);
    logic ebit;
    @(negedge clk);
    reset = r; load_valid = lv; data_in = din; hold = hd;
    #1;
    if (do_chk) begin
      for (int d = 0; d < 2; d++) begin
        ebit = m_busy[d] ? m_bits[d][m_idx[d]] : 1'b0;
        chk("load_ready",  d, lr[d], !m_busy[d]);
        chk("busy",        d, bz[d], m_busy[d]);
        chk("ser_out",     d, so[d], ebit);
        chk("ser_valid",   d, sv[d], m_busy[d] && !hd);
        chk("frame_start", d, fs[d], m_busy[d] && !hd && (m_idx[d] == 0));
        chk("frame_done",  d, fd[d], m_busy[d] && !hd && (m_idx[d] == FLEN - 1));
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_busy[d] = 1'b0;
        m_idx[d]  = 0;
      end else if (!m_busy[d] && lv) begin
        m_busy[d] = 1'b1;
        m_bits[d] = frame_bits(din, d == 1);
        m_idx[d]  = 0;
      end else if (m_busy[d] && !hd) begin
        m_idx[d]++;
        if (m_idx[d] == FLEN) m_busy[d] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_idx[d]  = 0;
      m_bits[d] = '0;
    end

    // Reset wins over a simultaneous load request.
    step(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Plain frame 1011, then idle through load_ready returning.
    step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b1);
    for (int i = 0; i < FLEN + 2; i++) step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Frame 0110 with two hold cycles on the second bit.
    step(1'b0, 1'b1, 4'b0110, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < FLEN + 1; i++) step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Frame 1001 aborted by reset after two bits, then a clean 0110.
    step(1'b0, 1'b1, 4'b1001, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'b0110, 1'b0, 1'b1);
    for (int i = 0; i < FLEN + 1; i++) step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Load requests while busy are ignored until load_ready returns.
    step(1'b0, 1'b1, 4'b1100, 1'b0, 1'b1);
    for (int i = 0; i < FLEN + 1; i++) step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < FLEN + 2; i++) step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Randomized traffic with holds and occasional resets.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 1) == 1),
           W'($urandom),
           ($urandom_range(0, 3) == 0),
           1'b1);
    end

    for (int i = 0; i < FLEN + 2; i++) step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
